// File: rtl/parity_tester.sv
// AXI-Stream byte-packet parity checker: buffers up to 16 bytes, replays them,
// then appends one trailer beat carrying the XOR (LRC) of the packet.
module parity_tester (
    input  logic       a_clk,
    input  logic       axis_aresetn,
    input  logic       axis_s_tvalid,
    input  logic [7:0] axis_s_tdata,
    output logic       axis_s_tready,
    input  logic       axis_s_tlast,
    output logic       axis_m_tvalid,
    output logic [7:0] axis_m_tdata,
    input  logic       axis_m_tready,
    output logic       axis_m_tlast
);

    typedef enum logic [1:0] {StRecv, StSendData, StSendLrc} state_e;

    state_e     state_q, state_d;
    logic [7:0] mem_q [16];
    logic [7:0] mem_d [16];
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] rd_q, rd_d;
    logic [7:0] lrc_q, lrc_d;
    logic       s_tready_q, s_tready_d;
    logic       m_tvalid_q, m_tvalid_d;
    logic [7:0] m_tdata_q, m_tdata_d;
    logic       m_tlast_q, m_tlast_d;
    logic       s_hs, m_hs;

    assign s_hs = s_tready_q & axis_s_tvalid;
    assign m_hs = m_tvalid_q & axis_m_tready;

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        lrc_d      = lrc_q;
        s_tready_d = s_tready_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        unique case (state_q)
            StRecv: begin
                s_tready_d = 1'b1;
                if (s_hs) begin
                    mem_d[cnt_q[3:0]] = axis_s_tdata;
                    cnt_d             = cnt_q + 5'd1;
                    lrc_d             = lrc_q ^ axis_s_tdata;
                    if (axis_s_tlast || cnt_q == 5'd15) begin
                        state_d    = StSendData;
                        rd_d       = 4'd0;
                        s_tready_d = 1'b0;
                        m_tvalid_d = 1'b1;
                        m_tlast_d  = 1'b0;
                        // A one-byte packet has not reached mem_q yet.
                        m_tdata_d  = (cnt_q == 5'd0) ? axis_s_tdata : mem_q[0];
                    end
                end
            end
            StSendData: begin
                if (m_hs) begin
                    rd_d = rd_q + 4'd1;
                    if ({1'b0, rd_q} == cnt_q - 5'd1) begin
                        state_d   = StSendLrc;
                        m_tdata_d = lrc_q;
                        m_tlast_d = 1'b1;
                    end else begin
                        m_tdata_d = mem_q[rd_q + 4'd1];
                    end
                end
            end
            StSendLrc: begin
                if (m_hs) begin
                    state_d    = StRecv;
                    cnt_d      = 5'd0;
                    rd_d       = 4'd0;
                    lrc_d      = 8'h00;
                    s_tready_d = 1'b1;
                    m_tvalid_d = 1'b0;
                    m_tdata_d  = 8'h00;
                    m_tlast_d  = 1'b0;
                end
            end
            default: state_d = StRecv;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (axis_aresetn) begin
            state_q    <= StRecv;
            cnt_q      <= 5'd0;
            rd_q       <= 4'd0;
            lrc_q      <= 8'h00;
            s_tready_q <= 1'b0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= 8'h00;
            m_tlast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            lrc_q      <= lrc_d;
            s_tready_q <= s_tready_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
        end
    end

    // Packet storage needs no reset; cnt_q alone decides which entries are live.
    always_ff @(posedge a_clk) begin
        mem_q <= mem_d;
    end

    assign axis_s_tready = s_tready_q;
    assign axis_m_tvalid = m_tvalid_q;
    assign axis_m_tdata  = m_tdata_q;
    assign axis_m_tlast  = m_tlast_q;

endmodule

// File: tb/tb_parity_tester.sv
// Self-checking bench for parity_tester: directed vector table, corner-case
// sequences and a randomized stream scored against a packet-level model.
module tb_parity_tester;

    logic       a_clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tvalid = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tlast = 1'b0;
    logic       m_tready = 1'b1;
    logic       s_tready;
    logic       m_tvalid;
    logic [7:0] m_tdata;
    logic       m_tlast;

    parity_tester dut (
        .a_clk         (a_clk),
        .axis_aresetn  (rst),
        .axis_s_tvalid (s_tvalid),
        .axis_s_tdata  (s_tdata),
        .axis_s_tready (s_tready),
        .axis_s_tlast  (s_tlast),
        .axis_m_tvalid (m_tvalid),
        .axis_m_tdata  (m_tdata),
        .axis_m_tready (m_tready),
        .axis_m_tlast  (m_tlast)
    );

    always #5 a_clk = ~a_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Packet-level reference model: bytes gather into a packet that closes on
    // tlast or at 16 bytes, then becomes N data beats plus one XOR trailer beat.
    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] pkt_q[$];
    logic [7:0] trl_q[$];
    logic [7:0] m_lrc = 8'h00;
    logic [7:0] first_exp = 8'h00;
    logic [7:0] prev_d = 8'h00;
    logic       prev_l = 1'b0;
    logic       prev_stall = 1'b0;
    logic       chk_first = 1'b0;
    logic       chk_after = 1'b0;
    logic       chk_rdy = 1'b0;
    logic       rst_prev = 1'b0;
    beat_t      mon_b;

    always @(negedge a_clk) begin
        if (rst) begin
            if (rst_prev) begin
                check("rst_m_tvalid", m_tvalid, 1'b0);
                check("rst_m_tlast", m_tlast, 1'b0);
                check("rst_m_tdata", m_tdata, 8'h00);
                check("rst_s_tready", s_tready, 1'b0);
            end
            exp_q.delete();
            pkt_q.delete();
            m_lrc      = 8'h00;
            chk_first  = 1'b0;
            chk_after  = 1'b0;
            chk_rdy    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (chk_rdy) check("s_tready_after_reset", s_tready, 1'b1);
            chk_rdy = rst_prev;
            if (chk_first) begin
                check("latency_m_tvalid", m_tvalid, 1'b1);
                check("latency_first_byte", m_tdata, first_exp);
                check("latency_s_tready_low", s_tready, 1'b0);
                chk_first = 1'b0;
            end
            if (chk_after) begin
                check("s_tready_after_trailer", s_tready, 1'b1);
                check("m_tvalid_after_trailer", m_tvalid, 1'b0);
                chk_after = 1'b0;
            end
            if (prev_stall) begin
                check("stall_m_tvalid", m_tvalid, 1'b1);
                check("stall_m_tdata", m_tdata, prev_d);
                check("stall_m_tlast", m_tlast, prev_l);
            end
            check("no_overlap", s_tready & m_tvalid, 1'b0);

            if (s_tvalid && s_tready) begin
                pkt_q.push_back(s_tdata);
                m_lrc = m_lrc ^ s_tdata;
                if (s_tlast || pkt_q.size() == 16) begin
                    foreach (pkt_q[i]) exp_q.push_back('{d: pkt_q[i], l: 1'b0});
                    exp_q.push_back('{d: m_lrc, l: 1'b1});
                    first_exp = pkt_q[0];
                    chk_first = 1'b1;
                    pkt_q.delete();
                    m_lrc = 8'h00;
                end
            end

            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat",
                             m_tdata, m_tlast);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("beat_data", m_tdata, mon_b.d);
                    check("beat_last", m_tlast, mon_b.l);
                    if (mon_b.l) begin
                        trl_q.push_back(m_tdata);
                        chk_after = 1'b1;
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
            prev_l     = m_tlast;
        end
        rst_prev = rst;
    end

    // Downstream ready: 0 always ready, 1 random, 2 fixed toggle pattern, 3 stalled.
    int bp_mode = 0;
    int pat_idx = 0;
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        forever begin
            @(posedge a_clk);
            #1;
            case (bp_mode)
                1: m_tready = 1'($urandom);
                2: begin
                    m_tready = pat[pat_idx % 6];
                    pat_idx++;
                end
                3: m_tready = 1'b0;
                default: m_tready = 1'b1;
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        bit done;
        int t;
        done = 1'b0;
        t    = 0;
        repeat (gap) begin
            s_tvalid = 1'b0;
            s_tdata  = 8'($urandom);
            s_tlast  = 1'($urandom);
            @(posedge a_clk);
            #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        while (!done) begin
            @(negedge a_clk);
            done = s_tready;
            @(posedge a_clk);
            #1;
            t++;
            if (!done && t > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: byte %0h not accepted, expected acceptance", d);
                done = 1'b1;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        bit done;
        int t;
        done     = 1'b0;
        t        = 0;
        s_tvalid = 1'b0;
        while (!done) begin
            @(negedge a_clk);
            done = (exp_q.size() == 0) && s_tready && !m_tvalid;
            t++;
            if (!done && t > 400) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d beats pending, expected 0", exp_q.size());
                done = 1'b1;
            end
        end
        @(posedge a_clk);
        #1;
    endtask

    typedef struct {
        logic [15:0][7:0] d;
        int               n;
        logic [7:0]       trailer;
        int               bp;
    } vec_t;

    vec_t vecs[5];
    int   tr0;
    int   len;

    initial begin
        vecs[0].d = '0; vecs[0].n = 1; vecs[0].trailer = 8'h5A; vecs[0].bp = 0;
        vecs[0].d[0] = 8'h5A;
        vecs[1].d = '0; vecs[1].n = 3; vecs[1].trailer = 8'h07; vecs[1].bp = 0;
        vecs[1].d[0] = 8'h01; vecs[1].d[1] = 8'h02; vecs[1].d[2] = 8'h04;
        vecs[2].d = '0; vecs[2].n = 3; vecs[2].trailer = 8'h00; vecs[2].bp = 0;
        vecs[2].d[0] = 8'h12; vecs[2].d[1] = 8'h34; vecs[2].d[2] = 8'h26;
        vecs[3].d = '0; vecs[3].n = 3; vecs[3].trailer = 8'h01; vecs[3].bp = 0;
        vecs[3].d[0] = 8'h12; vecs[3].d[1] = 8'h34; vecs[3].d[2] = 8'h27;
        vecs[4].d = '0; vecs[4].n = 2; vecs[4].trailer = 8'hFF; vecs[4].bp = 2;
        vecs[4].d[0] = 8'hAA; vecs[4].d[1] = 8'h55;

        repeat (3) @(posedge a_clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge a_clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            bp_mode = vecs[i].bp;
            pat_idx = 0;
            tr0     = trl_q.size();
            for (int j = 0; j < vecs[i].n; j++) begin
                send_byte(vecs[i].d[j], j == vecs[i].n - 1, (i == 4) ? 2 : 0);
            end
            drain();
            check("vec_trailer_count", trl_q.size() - tr0, 1);
            if (trl_q.size() > 0) check("vec_trailer", trl_q[$], vecs[i].trailer);
        end

        // 17 bytes without an early tlast: truncation after 0x0F, 0x10 starts anew.
        bp_mode = 0;
        tr0     = trl_q.size();
        for (int b = 0; b < 17; b++) send_byte(8'(b), b == 16, 0);
        drain();
        check("ovf_trailer_count", trl_q.size() - tr0, 2);
        if (trl_q.size() >= 2) begin
            check("ovf_trailer_full", trl_q[trl_q.size() - 2], 8'h00);
            check("ovf_trailer_new", trl_q[$], 8'h10);
        end

        // Abort a packet mid-replay with a two-cycle reset.
        bp_mode = 3;
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h33, 1'b1, 0);
        repeat (2) @(posedge a_clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge a_clk);
        #1;
        rst     = 1'b0;
        bp_mode = 0;
        tr0     = trl_q.size();
        send_byte(8'h3C, 1'b1, 0);
        drain();
        check("rst_trailer_count", trl_q.size() - tr0, 1);
        if (trl_q.size() > 0) check("rst_trailer", trl_q[$], 8'h3C);

        // Random stream with backpressure, idle gaps and over-long packets.
        bp_mode = 1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 20);
            for (int j = 0; j < len; j++) begin
                send_byte(8'($urandom), j == len - 1, $urandom_range(0, 2));
            end
        end
        bp_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/parity_tester.md
# parity_tester

AXI-Stream byte-packet parity checker. It accepts a packet on the slave port, stores it, and computes the running longitudinal XOR (LRC) of its bytes. It then replays the packet on the master port followed by one trailer byte holding the LRC. A trailer of 0x00 means the packet, including any embedded check byte, had even column parity. The block sits between a stream source and a consumer and is driven by a single clock.

## Interface
- No parameters. Buffer depth is fixed at 16 bytes; data width is fixed at 8 bits.
- a_clk  input  1  the single system clock; all logic is on its rising edge.
- axis_aresetn  input  1  reset, synchronous and active-high (asserted = 1), despite the name.
- axis_s_tvalid  input  1  slave data valid.
- axis_s_tdata  input  8  slave data byte.
- axis_s_tready  output  1  slave ready; registered.
- axis_s_tlast  input  1  marks the last byte of the input packet.
- axis_m_tvalid  output  1  master data valid; registered.
- axis_m_tdata  output  8  master data byte; registered.
- axis_m_tready  input  1  downstream ready.
- axis_m_tlast  output  1  asserted only on the trailer (LRC) beat; registered.

## Operation
- Storage: 16x8 buffer, 5-bit write count `cnt` (0..16), 4-bit read pointer `rd`, 8-bit accumulator `lrc`.
- The FSM has three states: RECV, SEND_DATA, SEND_LRC. Reset enters RECV.
- RECV:
  - s_tready = 1.
  - On an s handshake (tvalid & tready): `buf[cnt] <= tdata`, `cnt <= cnt+1`, `lrc <= lrc ^ tdata`.
  - If tlast = 1, or this byte is the 16th (cnt == 15 before the write), go to SEND_DATA with rd = 0.
  - A 16-byte packet without tlast is truncated. The next input byte starts a new packet.
- SEND_DATA:
  - s_tready = 0, m_tvalid = 1, m_tdata = buf[rd], m_tlast = 0.
  - On an m handshake: `rd <= rd+1`.
  - When the beat with rd == cnt-1 is accepted, go to SEND_LRC.
- SEND_LRC:
  - m_tvalid = 1, m_tdata = lrc, m_tlast = 1.
  - On an m handshake: clear cnt, rd and lrc to 0; set s_tready = 1; return to RECV.
- s_tdata and s_tlast are ignored when s_tvalid = 0.
- Each packet produces exactly N+1 output beats for N accepted bytes (1 <= N <= 16).
- While m_tvalid = 1 and m_tready = 0, m_tdata and m_tlast hold stable. m_tvalid never drops before its handshake.
- Reset values (any cycle, including mid-packet):
  - s_tready = 0 during reset, 1 on the first cycle after reset.
  - m_tvalid = 0, m_tdata = 0x00, m_tlast = 0.
  - cnt, rd and lrc cleared; the partial packet is discarded.

## Timing
- All outputs are registered. Reset is sampled on the rising edge of a_clk.
- Input: one byte per cycle while s_tvalid = 1.
- Latency: if the last input byte is accepted at edge k, m_tvalid is 1 with byte 0 in the cycle after edge k.
- Output: one beat per cycle while m_tready = 1. An N-byte packet drains in N+1 cycles with no backpressure.
- s_tready falls in the cycle after the last byte is accepted. It rises in the cycle after the trailer handshake, so there is one dead cycle between packets.
- No overlap: input and output phases never occur simultaneously.

## Test plan
- Single byte 0x5A with tlast, m_tready = 1 -> output 0x5A (tlast = 0), then 0x5A (tlast = 1); s_tready back to 1 one cycle later.
- Packet 0x01, 0x02, 0x04 (tlast on 0x04) -> output 0x01, 0x02, 0x04, then trailer 0x07 with tlast.
- Packet with embedded check byte 0x12, 0x34, 0x26 -> trailer 0x00 (parity pass). Packet 0x12, 0x34, 0x27 -> trailer 0x01.
- Backpressure: packet 0xAA, 0x55 with m_tready toggling 1-0-0-1-0-1 -> each beat is held stable until its handshake; sequence 0xAA, 0x55, 0xFF(tlast); no beat is duplicated or dropped. Gaps in s_tvalid during input leave lrc unchanged.
- Overflow: 17 bytes 0x00..0x10, no tlast -> after 0x0F, output 0x00..0x0F plus trailer 0x00. Byte 0x10 is accepted after the trailer as a new packet; a later tlast yields 0x10, 0x10.
- Reset asserted for 2 cycles during SEND_DATA -> m_tvalid = 0, m_tlast = 0, m_tdata = 0x00 during reset. s_tready = 1 after release. A new packet 0x3C(tlast) yields 0x3C, 0x3C with no residue of the aborted packet.
